// File: rtl/wave_display_multi.sv
// Multi-channel scope trace renderer: overlays NUM_CH sample traces from a double-buffered
// sample RAM onto the VGA pixel stream, with a 2-cycle registered pipeline.
module wave_display_multi #(
  parameter int unsigned                 NUM_CH   = 2,
  parameter int unsigned                 SAMP_W   = 8,
  parameter int unsigned                 X_START  = 256,
  parameter int unsigned                 HSHIFT   = 1,
  parameter int unsigned                 Y_LIMIT  = 512,
  parameter int unsigned                 YSHIFT   = 1,
  parameter int unsigned                 Y_OFFSET = 32,
  parameter logic [24*NUM_CH-1:0]        COLORS   = {24'hFFFFFF, 24'h00FF00}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           x,
  input  logic [9:0]            y,
  input  logic                  valid,
  input  logic                  pix_en,
  input  logic                  read_index,
  input  logic                  freeze,
  input  logic                  dot_mode,
  output logic [SAMP_W:0]       read_address,
  input  logic [8*NUM_CH-1:0]   read_value,
  output logic                  valid_pixel,
  output logic [7:0]            r,
  output logic [7:0]            g,
  output logic [7:0]            b
);

  localparam int unsigned WinW = 2 ** (SAMP_W + HSHIFT);
  localparam logic [11:0] XLo  = 12'(X_START);
  localparam logic [11:0] XHi  = 12'(X_START + WinW);
  localparam logic [10:0] YHi  = 11'(Y_LIMIT);

  // Stage 0: window decode and shared RAM address
  logic              disp_bank_q;
  logic [10:0]       x_off;
  logic [SAMP_W-1:0] idx;
  logic [9:0]        yc;
  logic              in_win;

  always_comb begin
    x_off  = x - 11'(X_START);
    idx    = SAMP_W'(x_off >> HSHIFT);
    yc     = y >> YSHIFT;
    in_win = valid & ({1'b0, x} >= XLo) & ({1'b0, x} < XHi) & ({1'b0, y} < YHi);
    read_address = in_win ? {disp_bank_q, idx} : '0;
  end

  // Stage 1: pixel attributes aligned with the RAM read latency
  logic              s1_valid_q;
  logic              s1_in_win_q;
  logic              s1_line_start_q;
  logic [SAMP_W-1:0] s1_idx_q;
  logic [9:0]        s1_yc_q;

  // Stage 2: per-channel trace state and hit test
  logic [NUM_CH-1:0][7:0] prev_q, prev_d;
  logic [NUM_CH-1:0][7:0] cur_q, cur_d;
  logic [SAMP_W-1:0]      last_idx_q, last_idx_d;
  logic [NUM_CH-1:0]      hit;
  logic                   upd;
  logic [23:0]            rgb_d;

  always_comb begin
    logic [7:0] p;
    logic [7:0] lo;
    logic [7:0] hi;
    prev_d     = prev_q;
    cur_d      = cur_q;
    last_idx_d = last_idx_q;
    hit        = '0;
    p          = '0;
    lo         = '0;
    hi         = '0;
    upd        = s1_valid_q & s1_in_win_q;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      // 8-bit wrap on the offset add is intentional
      p = {1'b0, read_value[8*c+1 +: 7]} + 8'(Y_OFFSET);
      if (upd) begin
        if (s1_line_start_q) begin
          prev_d[c] = p;
          cur_d[c]  = p;
        end else if (s1_idx_q != last_idx_q) begin
          prev_d[c] = cur_q[c];
          cur_d[c]  = p;
        end
      end
      lo = (prev_d[c] < cur_d[c]) ? prev_d[c] : cur_d[c];
      hi = (prev_d[c] < cur_d[c]) ? cur_d[c] : prev_d[c];
      if (dot_mode) begin
        hit[c] = (s1_yc_q == {2'b00, cur_d[c]});
      end else begin
        hit[c] = (s1_yc_q >= {2'b00, lo}) && (s1_yc_q <= {2'b00, hi});
      end
    end
    if (upd) begin
      last_idx_d = s1_idx_q;
    end
  end

  // Lowest-numbered channel has priority, so scan downward and let it overwrite
  always_comb begin
    rgb_d = '0;
    for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
      if (hit[c]) begin
        rgb_d = COLORS[24*c +: 24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_bank_q     <= 1'b0;
      s1_valid_q      <= 1'b0;
      s1_in_win_q     <= 1'b0;
      s1_line_start_q <= 1'b0;
      s1_idx_q        <= '0;
      s1_yc_q         <= '0;
      prev_q          <= '0;
      cur_q           <= '0;
      last_idx_q      <= '0;
      valid_pixel     <= 1'b0;
      r               <= '0;
      g               <= '0;
      b               <= '0;
    end else begin
      // Bank only changes at the frame origin so a frame never mixes banks
      if (pix_en && (x == '0) && (y == '0) && !freeze) begin
        disp_bank_q <= read_index;
      end
      s1_valid_q <= pix_en;
      if (pix_en) begin
        s1_in_win_q     <= in_win;
        s1_line_start_q <= ({1'b0, x} == XLo);
        s1_idx_q        <= idx;
        s1_yc_q         <= yc;
      end
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      last_idx_q <= last_idx_d;
      if (s1_valid_q) begin
        valid_pixel <= s1_in_win_q & (|hit);
        {r, g, b}   <= s1_in_win_q ? rgb_d : 24'h000000;
      end
    end
  end

endmodule
